// File: rtl/btb_trainer_pkg.sv
// Shared types and constants for the BTB trainer.
//  - EN/DIS      : active-low strobe levels used on every *_ control port
//  - BR_TAKEN    : encoding of a taken branch direction
//  - br_inst_type_e   : control-instruction class seen at fetch / resolved at commit
//  - btb_pred_entry_t : one queued fetch-time prediction
package btb_trainer_pkg;

  localparam int   ADDR_W   = 32;
  localparam logic EN       = 1'b0;
  localparam logic DIS      = 1'b1;
  localparam logic BR_TAKEN = 1'b1;

  typedef enum logic [2:0] {
    BRTYPE_NONE   = 3'd0,
    BRTYPE_BRANCH = 3'd1,
    BRTYPE_JUMP   = 3'd2,
    BRTYPE_CALL   = 3'd3,
    BRTYPE_RET    = 3'd4
  } br_inst_type_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tar;
    logic              taken;
    br_inst_type_e     br_type;
  } btb_pred_entry_t;

endpackage

// File: rtl/btb_trainer_pred_queue.sv
// In-order circular queue of fetch-time predictions.
//  clk, reset_    : clock, async active-low reset
//  push/pop/flush : requests (active-high, internal); push ignored when full or
//                   flushing, pop ignored when empty; flush wins over both
//  wdata          : entry written at tail
//  head_entry     : entry at head (combinational read)
//  count, full, empty, tail : occupancy and write pointer
module btb_trainer_pred_queue
  import btb_trainer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int IDX   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  btb_pred_entry_t wdata,
  output btb_pred_entry_t head_entry,
  output logic [IDX:0]    count,
  output logic            full,
  output logic            empty,
  output logic [IDX-1:0]  tail
);

  btb_pred_entry_t mem [DEPTH];
  logic [IDX-1:0]  head;
  logic            do_push, do_pop;

  assign full       = (count == (IDX+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full && !flush;
  assign do_pop     = pop && !empty;
  assign head_entry = mem[head];

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/btb_trainer.sv
// Commit-side BTB training producer. Fetch allocates a prediction per control
// instruction; commit pops the oldest one, compares it with the resolved
// outcome and emits a one-cycle registered training beat.
//  clk, reset_                 : clock, async active-low reset
//  pred_valid_, pred_*         : allocate from fetch (active-low valid)
//  pred_ready_, pred_id        : queue not full (active-low), tail slot
//  com_valid_, com_*           : resolved outcome of oldest instruction
//  flush_                      : discard queued predictions (active-low)
//  br_*/jump_*/com_pc/com_tar_addr : training beat, registered, active-low strobes
//  underflow                   : sticky, commit seen with an empty queue
module btb_trainer
  import btb_trainer_pkg::*;
#(
  parameter  int ADDR  = ADDR_W,  // must equal ADDR_W (entry struct width)
  parameter  int DEPTH = 16,
  localparam int IDX   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_,
  input  logic            pred_valid_,
  input  logic [ADDR-1:0] pred_pc,
  input  logic            pred_taken,
  input  logic [ADDR-1:0] pred_tar,
  input  br_inst_type_e   pred_type,
  output logic            pred_ready_,
  output logic [IDX-1:0]  pred_id,
  input  logic            com_valid_,
  input  br_inst_type_e   com_type,
  input  logic            com_taken,
  input  logic [ADDR-1:0] com_tar,
  input  logic            flush_,
  output logic            br_commit_,
  output logic            br_result,
  output logic            br_miss_,
  output logic            jump_commit_,
  output logic            jump_call_,
  output logic            jump_return_,
  output logic            jump_miss_,
  output logic [ADDR-1:0] com_pc,
  output logic [ADDR-1:0] com_tar_addr,
  output logic            underflow
);

  btb_pred_entry_t wdata, pe;
  logic [IDX:0]    count;
  logic            full, empty;
  logic            commit_req, commit;
  logic            br_miss, jump_miss;

  assign wdata       = '{pc: pred_pc, tar: pred_tar, taken: pred_taken, br_type: pred_type};
  assign pred_ready_ = full ? DIS : EN;
  assign commit_req  = (com_valid_ == EN);
  assign commit      = commit_req && !empty;

  btb_trainer_pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .reset_     (reset_),
    .push       (pred_valid_ == EN),
    .pop        (commit_req),
    .flush      (flush_ == EN),
    .wdata      (wdata),
    .head_entry (pe),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .tail       (pred_id)
  );

  // A taken branch also needs the right target; a not-taken one does not.
  assign br_miss   = (pe.taken != com_taken) || (com_taken && (pe.tar != com_tar));
  assign jump_miss = !pe.taken || (pe.tar != com_tar);

  // Strobes fall back to DIS every cycle so a beat lasts one cycle; data
  // fields hold their last value between beats.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      br_commit_   <= DIS;
      br_result    <= ~BR_TAKEN;
      br_miss_     <= DIS;
      jump_commit_ <= DIS;
      jump_call_   <= DIS;
      jump_return_ <= DIS;
      jump_miss_   <= DIS;
      com_pc       <= '0;
      com_tar_addr <= '0;
      underflow    <= 1'b0;
    end else begin
      br_commit_   <= DIS;
      br_miss_     <= DIS;
      jump_commit_ <= DIS;
      jump_call_   <= DIS;
      jump_return_ <= DIS;
      jump_miss_   <= DIS;
      if (commit_req && empty) underflow <= 1'b1;
      if (commit) begin
        case (com_type)
          BRTYPE_BRANCH: begin
            br_commit_   <= EN;
            br_result    <= com_taken;
            br_miss_     <= br_miss ? EN : DIS;
            com_pc       <= pe.pc;
            com_tar_addr <= com_tar;
          end
          BRTYPE_JUMP, BRTYPE_CALL, BRTYPE_RET: begin
            jump_commit_ <= EN;
            jump_call_   <= (com_type == BRTYPE_CALL) ? EN : DIS;
            jump_return_ <= (com_type == BRTYPE_RET)  ? EN : DIS;
            jump_miss_   <= jump_miss ? EN : DIS;
            com_pc       <= pe.pc;
            com_tar_addr <= com_tar;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
